// File: rtl/sys_pkg.sv
// Shared types for the systolic matmul feeder: element widths and the feeder state encoding.
package sys_pkg;

  localparam int unsigned DEF_DW = 8;
  localparam int unsigned DEF_CW = 16;

  typedef logic [DEF_DW-1:0] elem_t;
  typedef logic [DEF_CW-1:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    HOLD
  } feed_state_t;

endpackage

// File: rtl/sys_feeder.sv
// Input-side feeder for the systolic matmul array: takes one A/B pair, clears the array,
// streams column k of A and row k of B, zero-pads until the array reports C, then holds C.
module sys_feeder
  import sys_pkg::*;
#(
  parameter int unsigned M         = 3,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned CW        = DEF_CW,
  parameter int unsigned DRAIN_MAX = 4 * M
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [M-1:0][M-1:0][DW-1:0]  a_mat,
  input  logic [M-1:0][M-1:0][DW-1:0]  b_mat,
  output logic                         arr_clr,
  output logic [M-1:0][DW-1:0]         arr_a,
  output logic [M-1:0][DW-1:0]         arr_b,
  output logic                         arr_vld,
  output logic                         arr_rdy,
  input  logic                         arr_rdy_in,
  input  logic                         arr_vld_out,
  input  logic [M-1:0][M-1:0][CW-1:0]  arr_c,
  output logic [M-1:0][M-1:0][CW-1:0]  c_mat,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         out_err
);

  localparam int unsigned KW  = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned DCW = $clog2(DRAIN_MAX + 1);

  feed_state_t                 state;
  logic [KW-1:0]               k;
  logic [DCW-1:0]              drain_cnt;
  logic [M-1:0][M-1:0][DW-1:0] a_reg;
  logic [M-1:0][M-1:0][DW-1:0] b_reg;

  logic [KW-1:0]               k_sel_c;
  logic                        k_last_c;
  logic                        drain_done_c;
  logic [M-1:0][DW-1:0]        a_col_c;
  logic [M-1:0][DW-1:0]        b_row_c;

  // Next beat to present: beat 0 when leaving CLEAR, otherwise k+1 while streaming.
  always_comb begin
    k_last_c     = (k == KW'(M - 1));
    drain_done_c = ((drain_cnt + DCW'(1)) == DCW'(DRAIN_MAX));
    k_sel_c      = '0;
    if (state == STREAM && !k_last_c) begin
      k_sel_c = k + KW'(1);
    end
    a_col_c = '0;
    b_row_c = '0;
    for (int unsigned i = 0; i < M; i++) begin
      a_col_c[i] = a_reg[i][k_sel_c];
      b_row_c[i] = b_reg[k_sel_c][i];
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      drain_cnt <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      in_rdy    <= 1'b0;
      arr_clr   <= 1'b0;
      arr_a     <= '0;
      arr_b     <= '0;
      arr_vld   <= 1'b0;
      arr_rdy   <= 1'b0;
      c_mat     <= '0;
      out_vld   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      arr_clr <= 1'b0;
      unique case (state)
        IDLE: begin
          in_rdy  <= 1'b1;
          arr_vld <= 1'b0;
          arr_rdy <= 1'b0;
          arr_a   <= '0;
          arr_b   <= '0;
          if (in_vld && in_rdy) begin
            a_reg   <= a_mat;
            b_reg   <= b_mat;
            in_rdy  <= 1'b0;
            arr_clr <= 1'b1;
            state   <= CLEAR;
          end
        end

        CLEAR: begin
          k       <= '0;
          arr_vld <= 1'b1;
          arr_rdy <= 1'b1;
          arr_a   <= a_col_c;
          arr_b   <= b_row_c;
          state   <= STREAM;
        end

        // A stalled beat simply keeps its registered value.
        STREAM: begin
          if (arr_vld && arr_rdy_in) begin
            if (k_last_c) begin
              arr_a     <= '0;
              arr_b     <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              k     <= k + KW'(1);
              arr_a <= a_col_c;
              arr_b <= b_row_c;
            end
          end
        end

        // A result seen in the same cycle as the timeout takes priority.
        DRAIN: begin
          drain_cnt <= drain_cnt + DCW'(1);
          if (arr_vld_out || drain_done_c) begin
            c_mat   <= arr_c;
            out_err <= !arr_vld_out;
            out_vld <= 1'b1;
            arr_vld <= 1'b0;
            arr_rdy <= 1'b0;
            state   <= HOLD;
          end
        end

        HOLD: begin
          if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
            out_err <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_feeder.sv
// Bench for sys_feeder: stub MAC array, matrix-product reference model and a
// scoreboard of expected beats and results popped by an independent monitor.
module tb_sys_feeder;

  localparam int unsigned M         = 3;
  localparam int unsigned DW        = 8;
  localparam int unsigned CW        = 16;
  localparam int unsigned DRAIN_MAX = 4 * M;
  localparam int unsigned LAT       = 2;
  localparam int          BOUND     = 200;

  typedef logic [M-1:0][M-1:0][DW-1:0] mat_t;
  typedef logic [M-1:0][M-1:0][CW-1:0] cmat_t;
  typedef logic [M-1:0][DW-1:0]        vec_t;
  typedef struct { cmat_t c; logic err; } exp_t;
  typedef struct { vec_t a; vec_t b; }    beat_t;

  logic  CLK;
  logic  rst;
  logic  in_vld;
  logic  in_rdy;
  mat_t  a_mat;
  mat_t  b_mat;
  logic  arr_clr;
  vec_t  arr_a;
  vec_t  arr_b;
  logic  arr_vld;
  logic  arr_rdy;
  logic  arr_rdy_in;
  logic  arr_vld_out;
  cmat_t arr_c;
  cmat_t c_mat;
  logic  out_vld;
  logic  out_rdy;
  logic  out_err;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  beat_t beat_q[$];
  beat_t mon_bt;
  logic  rand_mode = 1'b0;
  logic  stub_never = 1'b0;

  int ga [M][M] = '{'{1, 1, 0}, '{0, 1, 0}, '{0, 1, 1}};
  int gb [M][M] = '{'{1, 0, 0}, '{0, 2, 0}, '{2, 0, 1}};

  sys_feeder #(.M(M), .DW(DW), .CW(CW), .DRAIN_MAX(DRAIN_MAX)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .a_mat      (a_mat),
    .b_mat      (b_mat),
    .arr_clr    (arr_clr),
    .arr_a      (arr_a),
    .arr_b      (arr_b),
    .arr_vld    (arr_vld),
    .arr_rdy    (arr_rdy),
    .arr_rdy_in (arr_rdy_in),
    .arr_vld_out(arr_vld_out),
    .arr_c      (arr_c),
    .c_mat      (c_mat),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_err    (out_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stub array: accumulates every accepted beat, reports vld_out LAT cycles after the M-th.
  cmat_t acc;
  int    nbeat;
  int    lat;
  logic  fired;
  assign arr_c = acc;

  always @(posedge CLK) begin
    if (rst || arr_clr) begin
      acc         <= '0;
      nbeat       <= 0;
      lat         <= 0;
      fired       <= 1'b0;
      arr_vld_out <= 1'b0;
    end else begin
      arr_vld_out <= 1'b0;
      if (nbeat < M) begin
        if (arr_vld && arr_rdy && arr_rdy_in) begin
          for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
              acc[i][j] <= acc[i][j] + CW'(arr_a[i]) * CW'(arr_b[j]);
          nbeat <= nbeat + 1;
        end
      end else if (!fired) begin
        if (lat == LAT - 1) begin
          arr_vld_out <= !stub_never;
          fired       <= 1'b1;
        end else begin
          lat <= lat + 1;
        end
      end
    end
  end

  function automatic void check(input string nm, input logic [159:0] act, input logic [159:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endfunction

  function automatic void fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s bound of %0d cycles expired", nm, BOUND);
  endfunction

  function automatic cmat_t ref_mul(input mat_t a, input mat_t b);
    cmat_t r;
    logic [CW-1:0] s;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        s = '0;
        for (int kk = 0; kk < M; kk++) s = s + CW'(a[i][kk]) * CW'(b[kk][j]);
        r[i][j] = s;
      end
    end
    return r;
  endfunction

  function automatic vec_t col_of(input mat_t a, input int k);
    vec_t v;
    for (int i = 0; i < M; i++) v[i] = a[i][k];
    return v;
  endfunction

  function automatic vec_t row_of(input mat_t b, input int k);
    vec_t v;
    for (int j = 0; j < M; j++) v[j] = b[k][j];
    return v;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) m[i][j] = DW'($urandom);
    return m;
  endfunction

  function automatic mat_t mk(input int v [M][M]);
    mat_t m;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) m[i][j] = DW'(v[i][j]);
    return m;
  endfunction

  function automatic mat_t mk_ident();
    mat_t m;
    m = '0;
    for (int i = 0; i < M; i++) m[i][i] = DW'(1);
    return m;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_mode) begin
      arr_rdy_in = ($urandom_range(0, 3) != 0);
      out_rdy    = ($urandom_range(0, 2) != 0);
    end
  endtask

  // Offer a pair, wait for acceptance and record what the array and output must see.
  task automatic send_pair(input mat_t a, input mat_t b, input logic err, output int waits);
    beat_t bt;
    exp_t  ex;
    a_mat  = a;
    b_mat  = b;
    in_vld = 1'b1;
    waits  = 0;
    while (!in_rdy && waits < BOUND) begin
      tick();
      waits++;
    end
    if (!in_rdy) begin
      fail("accept_wait");
      in_vld = 1'b0;
      return;
    end
    tick();
    in_vld = 1'b0;
    a_mat  = rand_mat();
    b_mat  = rand_mat();
    ex.c   = ref_mul(a, b);
    ex.err = err;
    exp_q.push_back(ex);
    for (int k = 0; k < M; k++) begin
      bt.a = col_of(a, k);
      bt.b = row_of(b, k);
      beat_q.push_back(bt);
    end
    check("clr_pulse", 160'(arr_clr), 160'(1'b1));
    check("clear_in_rdy", 160'(in_rdy), 160'(1'b0));
    check("clear_arr_vld", 160'(arr_vld), 160'(1'b0));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BOUND) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) fail("result_wait");
  endtask

  task automatic wait_out_vld(output int n);
    n = 0;
    while (!out_vld && n < BOUND) begin
      tick();
      n++;
    end
    if (!out_vld) fail("out_vld_wait");
  endtask

  // Monitor: every accepted beat and every presented result is compared with the scoreboard.
  always @(negedge CLK) begin
    if (!rst) begin
      if (arr_vld && arr_rdy_in) begin
        if (beat_q.size() != 0) begin
          mon_bt = beat_q.pop_front();
          check("beat_a", 160'(arr_a), 160'(mon_bt.a));
          check("beat_b", 160'(arr_b), 160'(mon_bt.b));
        end else begin
          check("pad_a", 160'(arr_a), 160'(0));
          check("pad_b", 160'(arr_b), 160'(0));
        end
      end
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got out_vld=1 want 0");
        end else begin
          check("c_mat", 160'(c_mat), 160'(exp_q[0].c));
          check("out_err", 160'(out_err), 160'(exp_q[0].err));
          check("hold_in_rdy", 160'(in_rdy), 160'(1'b0));
          if (out_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int   w;
    int   n;
    mat_t ra;
    mat_t rb;

    rst        = 1'b1;
    in_vld     = 1'b0;
    a_mat      = '0;
    b_mat      = '0;
    arr_rdy_in = 1'b1;
    out_rdy    = 1'b1;
    tick();
    tick();
    check("rst_in_rdy", 160'(in_rdy), 160'(1'b0));
    check("rst_arr_clr", 160'(arr_clr), 160'(1'b0));
    check("rst_arr_vld", 160'(arr_vld), 160'(1'b0));
    check("rst_arr_rdy", 160'(arr_rdy), 160'(1'b0));
    check("rst_out_vld", 160'(out_vld), 160'(1'b0));
    check("rst_out_err", 160'(out_err), 160'(1'b0));
    check("rst_arr_a", 160'(arr_a), 160'(0));
    check("rst_c_mat", 160'(c_mat), 160'(0));
    rst = 1'b0;
    tick();
    check("idle_in_rdy", 160'(in_rdy), 160'(1'b1));

    // Identity, with end-to-end latency.
    send_pair(mk_ident(), mk_ident(), 1'b0, w);
    wait_out_vld(n);
    check("ident_latency", 160'(n), 160'(M + 2 + LAT));
    wait_drain();

    // General case.
    send_pair(mk(ga), mk(gb), 1'b0, w);
    wait_drain();

    // Two-cycle stall on beat 1.
    ra = rand_mat();
    rb = rand_mat();
    send_pair(ra, rb, 1'b0, w);
    tick();
    tick();
    arr_rdy_in = 1'b0;
    check("stall_a0", 160'(arr_a), 160'(col_of(ra, 1)));
    tick();
    check("stall_a1", 160'(arr_a), 160'(col_of(ra, 1)));
    check("stall_b1", 160'(arr_b), 160'(row_of(rb, 1)));
    tick();
    check("stall_a2", 160'(arr_a), 160'(col_of(ra, 1)));
    arr_rdy_in = 1'b1;
    tick();
    check("stall_next", 160'(arr_a), 160'(col_of(ra, 2)));
    tick();
    check("stall_drain_a", 160'(arr_a), 160'(0));
    check("stall_drain_vld", 160'(arr_vld), 160'(1'b1));
    wait_drain();

    // Output backpressure; a pair offered during HOLD must be ignored until IDLE.
    send_pair(rand_mat(), rand_mat(), 1'b0, w);
    out_rdy = 1'b0;
    wait_out_vld(n);
    ra     = rand_mat();
    rb     = rand_mat();
    a_mat  = ra;
    b_mat  = rb;
    in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_vld", 160'(out_vld), 160'(1'b1));
      check("bp_in_rdy", 160'(in_rdy), 160'(1'b0));
    end
    out_rdy = 1'b1;
    tick();
    check("hs_out_vld", 160'(out_vld), 160'(1'b0));
    check("hs_in_rdy", 160'(in_rdy), 160'(1'b1));
    send_pair(ra, rb, 1'b0, w);
    check("accept_after_hs", 160'(w), 160'(0));
    wait_drain();

    // Drain timeout.
    stub_never = 1'b1;
    send_pair(rand_mat(), rand_mat(), 1'b1, w);
    wait_out_vld(n);
    check("timeout_latency", 160'(n), 160'(M + 1 + DRAIN_MAX));
    wait_drain();
    stub_never = 1'b0;

    // Reset while beat 1 is on the array.
    send_pair(rand_mat(), rand_mat(), 1'b0, w);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mrst_in_rdy", 160'(in_rdy), 160'(1'b0));
    check("mrst_arr_vld", 160'(arr_vld), 160'(1'b0));
    check("mrst_arr_a", 160'(arr_a), 160'(0));
    check("mrst_arr_b", 160'(arr_b), 160'(0));
    check("mrst_out_vld", 160'(out_vld), 160'(1'b0));
    check("mrst_c_mat", 160'(c_mat), 160'(0));
    rst = 1'b0;
    exp_q.delete();
    beat_q.delete();
    tick();
    check("mrst_in_rdy_after", 160'(in_rdy), 160'(1'b1));
    send_pair(mk_ident(), mk_ident(), 1'b0, w);
    wait_drain();

    // Random pairs with random array stalls and output backpressure.
    rand_mode = 1'b1;
    for (int p = 0; p < 12; p++) begin
      send_pair(rand_mat(), rand_mat(), 1'b0, w);
    end
    wait_drain();
    rand_mode  = 1'b0;
    arr_rdy_in = 1'b1;
    out_rdy    = 1'b1;
    wait_drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
